// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready FIFO controller in front of a 1-cycle-latency dual-port RAM
//
// Purpose: turns a bare dual-port RAM (DEPTH = 2**ADDR_W words) into a FIFO.
// Writes go straight to the RAM. Reads are prefetched into a 2-entry
// show-ahead output buffer, which sustains one push and one pop per cycle.
//
// Ports:
//   clock, rst_n        rising-edge clock, asynchronous active-low reset
//   flush               synchronous clear of all contents
//   in_data/in_valid/in_ready     push stream
//   out_data/out_valid/out_ready  show-ahead pop stream
//   level               entries held (RAM + in-flight read + output buffer)
//   ram_data/ram_wraddress/ram_wren  RAM write port
//   ram_rdaddress/ram_q              RAM read port (q valid one cycle after address)
module ram_fifo_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W+1:0] level,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic [ADDR_W:0]   mem_cnt_n;
  logic              rd_pend;
  logic [1:0]        obuf_cnt;
  logic [1:0]        obuf_cnt_n;
  logic [DATA_W-1:0] obuf0;
  logic [DATA_W-1:0] obuf1;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W+1:0] level_q;
  logic              push;
  logic              pop;
  logic              issue;
  logic              capture;
  logic [2:0]        occ;

  // rst_n is folded in so upstream sees back-pressure the moment reset asserts.
  assign in_ready  = rst_n && !flush && (mem_cnt != DEPTH);
  assign push      = in_valid && in_ready;
  assign out_valid = (obuf_cnt != 2'd0);
  assign out_data  = obuf0;
  assign pop       = out_valid && out_ready;

  // Output-side occupancy after this cycle's pop; the in-flight read counts
  // as occupied, so the buffer can never be over-committed.
  assign occ     = {1'b0, obuf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign issue   = !flush && (mem_cnt != '0) && (occ < 3'd2);
  assign capture = rd_pend && !flush;

  assign ram_wren      = push;
  assign ram_wraddress = wr_ptr[ADDR_W-1:0];
  assign ram_data      = in_data;
  assign ram_rdaddress = issue ? rd_ptr[ADDR_W-1:0] : rd_addr_q;

  assign mem_cnt_n  = flush ? '0
                    : mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
  assign obuf_cnt_n = flush ? 2'd0
                    : obuf_cnt - {1'b0, pop} + {1'b0, capture};

  assign level = level_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      rd_pend   <= 1'b0;
      obuf_cnt  <= 2'd0;
      obuf0     <= '0;
      obuf1     <= '0;
      rd_addr_q <= '0;
      level_q   <= '0;
    end else begin
      mem_cnt  <= mem_cnt_n;
      obuf_cnt <= obuf_cnt_n;
      rd_pend  <= issue;
      level_q  <= {1'b0, mem_cnt_n}
                + {{(ADDR_W+1){1'b0}}, issue}
                + {{ADDR_W{1'b0}}, obuf_cnt_n};
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        rd_addr_q <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
        if (issue) begin
          rd_ptr    <= rd_ptr + (ADDR_W+1)'(1);
          rd_addr_q <= rd_ptr[ADDR_W-1:0];
        end
        if (pop)
          obuf0 <= obuf1;
        // Returning data lands behind whatever survives this cycle's pop.
        if (capture) begin
          if (obuf_cnt == {1'b0, pop})
            obuf0 <= ram_q;
          else
            obuf1 <= ram_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - self-checking bench for ram_fifo_ctrl with a behavioural RAM and queue model
module tb_ram_fifo_ctrl;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic [3:0] ram_data;
  logic [2:0] ram_wraddress;
  logic       ram_wren;
  logic [2:0] ram_rdaddress;
  logic [3:0] ram_q;

  always #5 clock = ~clock;

  ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(3)) dut (
    .clock(clock), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level),
    .ram_data(ram_data), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  // Dual-port RAM with registered read: q follows the address by one cycle.
  logic [3:0] ram_mem [8];
  always @(posedge clock) begin
    if (ram_wren) ram_mem[ram_wraddress] <= ram_data;
    ram_q <= ram_mem[ram_rdaddress];
  end

  // Reference model: ordered queue of held entries; each entry becomes
  // visible at the head two edges after the edge that accepted it.
  typedef struct {
    logic [3:0] val;
    int         rdy;
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   wr_count = 0;
  int   pops     = 0;
  int   pushes   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic f);
    logic push;
    logic exp_valid;
    ent_t e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (cyc >= q[0].rdy);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("out_data", out_data, q[0].val);
    check("level", level, q.size());
    push = v && in_ready;
    check("ram_wren", ram_wren, push);
    if (f) check("in_ready_flush", in_ready, 0);
    if (q.size() == 10) check("in_ready_full", in_ready, 0);
    if (q.size() < 8 && !f) check("in_ready_room", in_ready, 1);
    if (push) begin
      check("wraddr", ram_wraddress, wr_count % 8);
      check("ram_data", ram_data, d);
    end
    @(posedge clock);
    cyc++;
    if (f) begin
      q.delete();
      wr_count = 0;
    end else begin
      if (exp_valid && r) begin
        void'(q.pop_front());
        pops++;
      end
      if (push) begin
        e.val = d;
        e.rdy = cyc + 2;
        q.push_back(e);
        wr_count++;
        pushes++;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_wraddr", ram_wraddress, 0);
    check("rst_rdaddr", ram_rdaddress, 0);
    @(negedge clock);
    rst_n = 1'b1;

    // Single push, latency 2
    cycle(1, 4'h5, 1, 0);
    in_valid = 1'b0;
    #1;
    check("first_rdaddr", ram_rdaddress, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    check("single_pops", pops, 1);
    check("single_level", level, 0);

    // Fill to 10 with consumer stalled
    acc = 0;
    n = 0;
    while (acc < 10 && n < 40) begin
      cycle(1, 4'(acc + 1), 0, 0);
      acc = pushes - 1;
      n++;
    end
    check("fill_accepted", acc, 10);
    for (int i = 0; i < 3; i++) cycle(1, 4'hF, 0, 0);
    check("full_level", level, 10);
    check("full_pushes", pushes, 11);
    cycle(0, 0, 1, 0);
    #1;
    check("in_ready_after_first_read", in_ready, 1);
    for (int i = 0; i < 14; i++) cycle(0, 0, 1, 0);
    check("drain_pops", pops, 11);

    // Continuous push/pop of 0..15
    for (int i = 0; i < 19; i++) begin
      check("level_le3", (level <= 3), 1);
      cycle(i < 16, 4'(i), 1, 0);
    end
    check("stream_pops", pops, 27);

    // Random traffic, two back-pressure regimes
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            (i < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);
    check("random_drained", q.size(), 0);
    check("random_level", level, 0);
    check("random_balance", pops, pushes);

    // Flush with a read in flight
    cycle(1, 4'hA, 0, 0);
    cycle(1, 4'hB, 0, 0);
    cycle(1, 4'hC, 0, 0);
    cycle(1, 4'hD, 0, 1);
    check("flush_level", level, 0);
    check("flush_out_valid", out_valid, 0);
    n = pops;
    cycle(1, 4'h3, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    check("post_flush_pops", pops - n, 1);

    // Asynchronous reset mid-stream
    cycle(1, 4'h1, 0, 0);
    cycle(1, 4'h2, 0, 0);
    cycle(1, 4'h4, 0, 0);
    in_valid = 1'b1;
    out_ready = 1'b0;
    #3;
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_wren", ram_wren, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_level", level, 0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    q.delete();
    wr_count = 0;
    n = pops;
    cycle(1, 4'h7, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    check("post_reset_pops", pops - n, 1);
    check("post_reset_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
